// File: rtl/mem_req_arbiter.sv
// Serializes datapath fetch and data requests onto one word-wide RAM port, data first.
// A RAM access that never completes is ended after MAX_WAIT strobe cycles, with a sticky err.
module mem_req_arbiter #(
    parameter int unsigned MAX_WAIT = 15,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic [31:0] dmemload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {T_IRD, T_DRD, T_DWR} kind_t;

    state_t        state_q;
    kind_t         kind_q, kind_d;
    logic          grant_d;
    logic [31:0]   addr_d;
    logic [31:0]   resp_d;
    logic          done_d;
    logic [CW-1:0] cnt_q;
    logic          ihit_q, dhit_q, ren_q, wen_q, err_q;
    logic [31:0]   iload_q, dload_q, raddr_q, rstore_q;

    // The RAM is word-addressed; the byte-offset bits of both request addresses are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imemaddr[1:0], dmemaddr[1:0]};

    always_comb begin
        grant_d = 1'b1;
        kind_d  = T_IRD;
        addr_d  = {imemaddr[31:2], 2'b00};
        if (dmemWEN) begin
            kind_d = T_DWR;
            addr_d = {dmemaddr[31:2], 2'b00};
        end else if (dmemREN) begin
            kind_d = T_DRD;
            addr_d = {dmemaddr[31:2], 2'b00};
        end else if (!imemREN) begin
            grant_d = 1'b0;
        end
    end

    // A timeout completes the access exactly like a ready RAM, but with the error word.
    assign done_d = ramready || (cnt_q == CW'(MAX_WAIT - 1));
    assign resp_d = ramready ? ramload : ERR_WORD;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            kind_q   <= T_IRD;
            cnt_q    <= '0;
            ihit_q   <= 1'b0;
            dhit_q   <= 1'b0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
            iload_q  <= '0;
            dload_q  <= '0;
            raddr_q  <= '0;
            rstore_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_d) begin
                        kind_q   <= kind_d;
                        raddr_q  <= addr_d;
                        rstore_q <= dmemstore;
                        cnt_q    <= '0;
                        ren_q    <= (kind_d != T_DWR);
                        wen_q    <= (kind_d == T_DWR);
                        state_q  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (done_d) begin
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        ihit_q  <= (kind_q == T_IRD);
                        dhit_q  <= (kind_q != T_IRD);
                        iload_q <= (kind_q == T_IRD) ? resp_d : '0;
                        dload_q <= (kind_q == T_DRD) ? resp_d : '0;
                        err_q   <= err_q | !ramready;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    ihit_q  <= 1'b0;
                    dhit_q  <= 1'b0;
                    iload_q <= '0;
                    dload_q <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imemload = iload_q;
    assign dmemload = dload_q;
    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = raddr_q;
    assign ramstore = rstore_q;
    assign err      = err_q;

endmodule
